camera_readout_controller: RTL and testbench
============================================

# camera_readout_controller

Parametrised successor to the fixed 200×200 camera command block. It decodes camera SPI op-codes and holds a capture state machine gated by the capture pipeline's frame_valid. It owns runtime-configurable resolution and pixel mode, and streams the frame buffer to the host byte-by-byte with a clamped bytes-remaining count. It sits between the SPI subperipheral op-code bus and the camera frame-buffer RAM, in the SPI clock domain.

## Interface
Parameters:
- WORD_WIDTH, 32, frame-buffer RAM word width; multiple of 8, 8..64
- ADDRESS_WIDTH, 14, frame-buffer word address width
- DEFAULT_X_RESOLUTION, 200, x resolution after reset (10 bit)
- DEFAULT_Y_RESOLUTION, 200, y resolution after reset (10 bit)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clock_spi_in  in  1  single clock, 72 MHz
- reset_spi_n_in  in  1  asynchronous, active-low reset
- op_code_in  in  8  current op-code
- op_code_valid_in  in  1  op-code valid for the whole SPI transaction
- operand_in  in  8  current operand byte
- operand_valid_in  in  1  operand strobe; level, one pulse per operand byte
- operand_count_in  in  32 (integer)  index of the current operand
- response_out  out  8  response byte
- response_valid_out  out  1  response valid
- frame_valid_in  in  1  capture-pipeline frame valid; asynchronous, synchronised internally
- capture_enable_out  out  1  frame-buffer write gate
- buffer_read_address_out  out  ADDRESS_WIDTH  RAM read word address
- buffer_read_data_in  in  WORD_WIDTH  RAM read data; one-cycle synchronous latency
- x_resolution_out  out  10  active x resolution
- y_resolution_out  out  10  active y resolution
- pixel_mode_out  out  2  active pixel mode

## Operation
- Reset values:
  - response_out=0, response_valid_out=0, capture_enable_out=0
  - buffer_read_address_out=0, bytes_read=0
  - x/y = defaults, pixel_mode=1, state IDLE
- frame_valid_in passes through a 2-flop synchroniser, then an edge monitor of 1 previous sample.
- operand_valid_in goes through a 1-sample edge monitor; rise = current 1 and previous 0.
- FSM:
  - IDLE → ARMED on 0x20.
  - ARMED → CAPTURING on synced frame_valid rise.
  - CAPTURING → DONE on synced frame_valid fall.
  - DONE → ARMED on 0x20.
  - capture_enable_out=1 only in CAPTURING, registered.
- Op-codes (active only while op_code_valid_in=1):
  - 0x20 capture: in IDLE/DONE, state→ARMED and bytes_read←0. Ignored in ARMED/CAPTURING.
  - 0x21 bytes available: bytes_remaining=capture_size−bytes_read, 24 bit. Operand_count 0/1/2 → bits [23:16]/[15:8]/[7:0]; other counts → 0x00.
  - 0x22 read data: response = byte bytes_read mod (WORD_WIDTH/8) of the RAM word, big-endian (byte 0 = MSBs). On each operand rise, bytes_read increments, saturating at capture_size. At saturation the response is 0x00.
  - 0x23 configure: applied on operand rise, only in IDLE/DONE, otherwise ignored. Operand 0 → x[9:8], 1 → x[7:0], 2 → y[9:8], 3 → y[7:0], 4 → mode[1:0]; higher operands ignored. Response 0x00.
  - 0x24 status: {5'b0, state==DONE, state==CAPTURING, state==ARMED}.
  - Other op-codes: response_valid_out=1, response 0x00.
- capture_size, registered and recomputed the cycle after any configuration change:
  - mode 0 gray4: ceil(x·y/2)
  - mode 1 rgb8: x·y
  - mode 2 rgb10: 2·x·y
  - mode 3: treated as mode 1
  - Clamped to 2^ADDRESS_WIDTH·WORD_WIDTH/8 bytes.
- buffer_read_address_out = bytes_read / (WORD_WIDTH/8), truncated to ADDRESS_WIDTH; registered.

## Timing
- response_valid_out rises the cycle after op_code_valid_in rises and falls the cycle after it falls.
- Read path: bytes_read update → address register (+1) → RAM data (+2) → response_out (+3). The host byte period (≥8 SPI clocks at 72 MHz) always covers this.
- frame_valid_in edge → state change: 3 cycles.
- 0x20 on the same cycle as a synced frame_valid rise while in DONE: goes to ARMED; that rise is not consumed. Capture starts on the next rise.
- Armed while frame_valid is already high: waits for the next rise; no partial frames.
- Reset asserted mid-capture: capture_enable_out=0 asynchronously, state IDLE. Configuration returns to defaults.

## Test plan
- Reset, 0x21 operands 0..2 → 0x00, 0x9C, 0x40 (40000); 0x24 → 0x00.
- 0x20, then frame_valid pulse of 1000 cycles → status ARMED (0x01), CAPTURING (0x02) with capture_enable_out=1, DONE (0x04) with capture_enable_out=0.
- RAM word 0 = 0xAABBCCDD, word 1 = 0x11223344; 0x22 with 6 operand strobes → AA, BB, CC, DD, 11, 22. 0x21 then gives 39994.
- 0x23 with x=320, y=240, mode 2 in IDLE → capture_size clamps to 65536 (ADDRESS_WIDTH=14, WORD_WIDTH=32). The same 0x23 during CAPTURING leaves 200×200/mode 1 unchanged.
- Saturation: x=4, y=2, mode 0 → size 4. The 5th read returns 0x00 and bytes remaining stays 0.
- 0x20 during CAPTURING ignored; reset mid-CAPTURING → capture_enable_out=0 immediately, status 0x00.

Source files
------------

// File: rtl/camera_readout_controller_if.sv
// SPI subperipheral op-code bus between the SPI front end and the camera readout controller.
interface camera_readout_controller_if;
  logic [7:0]  op_code_in;
  logic        op_code_valid_in;
  logic [7:0]  operand_in;
  logic        operand_valid_in;
  logic [31:0] operand_count_in;
  logic [7:0]  response_out;
  logic        response_valid_out;

  modport master (
    output op_code_in, op_code_valid_in, operand_in, operand_valid_in, operand_count_in,
    input  response_out, response_valid_out
  );

  modport slave (
    input  op_code_in, op_code_valid_in, operand_in, operand_valid_in, operand_count_in,
    output response_out, response_valid_out
  );
endinterface

// File: rtl/camera_readout_controller.sv
// Camera op-code decoder: capture FSM gated by synchronised frame_valid, runtime resolution/mode,
// and big-endian byte streaming of the frame buffer with a clamped bytes-remaining count.
module camera_readout_controller #(
  parameter int unsigned WORD_WIDTH           = 32,
  parameter int unsigned ADDRESS_WIDTH        = 14,
  parameter int unsigned DEFAULT_X_RESOLUTION = 200,
  parameter int unsigned DEFAULT_Y_RESOLUTION = 200
) (
  input  logic                     clock_spi_in,
  input  logic                     reset_spi_n_in,
  camera_readout_controller_if.slave spi,
  input  logic                     frame_valid_in,
  output logic                     capture_enable_out,
  output logic [ADDRESS_WIDTH-1:0] buffer_read_address_out,
  input  logic [WORD_WIDTH-1:0]    buffer_read_data_in,
  output logic [9:0]               x_resolution_out,
  output logic [9:0]               y_resolution_out,
  output logic [1:0]               pixel_mode_out
);

  localparam int unsigned BPW       = WORD_WIDTH / 8;
  localparam int unsigned CNT_W     = 24;
  localparam logic [63:0] MAX_BYTES = (64'd1 << ADDRESS_WIDTH) * 64'(BPW);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ARMED     = 2'd1;
  localparam logic [1:0] S_CAPTURING = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam logic [7:0] OP_CAPTURE   = 8'h20;
  localparam logic [7:0] OP_AVAILABLE = 8'h21;
  localparam logic [7:0] OP_READ      = 8'h22;
  localparam logic [7:0] OP_CONFIGURE = 8'h23;
  localparam logic [7:0] OP_STATUS    = 8'h24;

  // Frame size in bytes for a given geometry/mode, clamped to the buffer capacity.
  function automatic logic [CNT_W-1:0] frame_bytes(input logic [9:0] x, input logic [9:0] y,
                                                   input logic [1:0] mode);
    logic [63:0] xy;
    logic [63:0] sz;
    xy = 64'(x) * 64'(y);
    case (mode)
      2'd0:    sz = (xy + 64'd1) >> 1;
      2'd2:    sz = xy << 1;
      default: sz = xy;
    endcase
    if (sz > MAX_BYTES) sz = MAX_BYTES;
    return CNT_W'(sz);
  endfunction

  localparam logic [9:0]       X_RST    = 10'(DEFAULT_X_RESOLUTION);
  localparam logic [9:0]       Y_RST    = 10'(DEFAULT_Y_RESOLUTION);
  localparam logic [CNT_W-1:0] SIZE_RST = frame_bytes(X_RST, Y_RST, 2'd1);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       bytes_read_q, bytes_read_d;
  logic [CNT_W-1:0]       capture_size_q;
  logic [9:0]             x_q, x_d, y_q, y_d;
  logic [1:0]             mode_q, mode_d;
  logic [7:0]             response_q, response_d;
  logic                   response_valid_q;
  logic                   capture_enable_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                   fv_meta_q, fv_sync_q, fv_prev_q;
  logic                   opv_prev_q;

  logic                   fv_rise, fv_fall, operand_rise, cfg_open, cmd_capture;
  logic [CNT_W-1:0]       remaining;
  logic [2:0]             byte_idx;
  logic [5:0]             byte_shift;
  logic [WORD_WIDTH-1:0]  word_shifted;

  assign fv_rise      = fv_sync_q & ~fv_prev_q;
  assign fv_fall      = ~fv_sync_q & fv_prev_q;
  assign operand_rise = spi.operand_valid_in & ~opv_prev_q;
  assign cfg_open     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cmd_capture  = spi.op_code_valid_in && (spi.op_code_in == OP_CAPTURE);
  assign remaining    = capture_size_q - bytes_read_q;
  assign byte_idx     = 3'(bytes_read_q % CNT_W'(BPW));
  assign byte_shift   = {3'(3'(BPW - 1) - byte_idx), 3'b000};
  assign word_shifted = buffer_read_data_in >> byte_shift;

  // Next-state, configuration and response decode.
  always_comb begin
    state_d      = state_q;
    bytes_read_d = bytes_read_q;
    x_d          = x_q;
    y_d          = y_q;
    mode_d       = mode_q;
    response_d   = 8'h00;

    case (state_q)
      S_IDLE:      if (cmd_capture) state_d = S_ARMED;
      S_ARMED:     if (fv_rise)     state_d = S_CAPTURING;
      S_CAPTURING: if (fv_fall)     state_d = S_DONE;
      S_DONE:      if (cmd_capture) state_d = S_ARMED;
      default:                      state_d = S_IDLE;
    endcase

    if (cmd_capture && cfg_open) begin
      bytes_read_d = '0;
    end else if (spi.op_code_valid_in && spi.op_code_in == OP_READ && operand_rise &&
                 bytes_read_q < capture_size_q) begin
      bytes_read_d = bytes_read_q + CNT_W'(1);
    end

    if (spi.op_code_valid_in && spi.op_code_in == OP_CONFIGURE && operand_rise && cfg_open) begin
      case (spi.operand_count_in)
        32'd0:   x_d[9:8] = spi.operand_in[1:0];
        32'd1:   x_d[7:0] = spi.operand_in;
        32'd2:   y_d[9:8] = spi.operand_in[1:0];
        32'd3:   y_d[7:0] = spi.operand_in;
        32'd4:   mode_d   = spi.operand_in[1:0];
        default: ;
      endcase
    end

    if (spi.op_code_valid_in) begin
      case (spi.op_code_in)
        OP_AVAILABLE: begin
          case (spi.operand_count_in)
            32'd0:   response_d = remaining[23:16];
            32'd1:   response_d = remaining[15:8];
            32'd2:   response_d = remaining[7:0];
            default: response_d = 8'h00;
          endcase
        end
        OP_READ:   response_d = (bytes_read_q >= capture_size_q) ? 8'h00 : word_shifted[7:0];
        OP_STATUS: response_d = {5'b0, state_q == S_DONE, state_q == S_CAPTURING,
                                 state_q == S_ARMED};
        default:   response_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      state_q          <= S_IDLE;
      bytes_read_q     <= '0;
      capture_size_q   <= SIZE_RST;
      x_q              <= X_RST;
      y_q              <= Y_RST;
      mode_q           <= 2'd1;
      response_q       <= 8'h00;
      response_valid_q <= 1'b0;
      capture_enable_q <= 1'b0;
      address_q        <= '0;
      fv_meta_q        <= 1'b0;
      fv_sync_q        <= 1'b0;
      fv_prev_q        <= 1'b0;
      opv_prev_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      bytes_read_q     <= bytes_read_d;
      capture_size_q   <= frame_bytes(x_q, y_q, mode_q);
      x_q              <= x_d;
      y_q              <= y_d;
      mode_q           <= mode_d;
      response_q       <= response_d;
      response_valid_q <= spi.op_code_valid_in;
      capture_enable_q <= (state_d == S_CAPTURING);
      address_q        <= ADDRESS_WIDTH'(bytes_read_q / CNT_W'(BPW));
      fv_meta_q        <= frame_valid_in;
      fv_sync_q        <= fv_meta_q;
      fv_prev_q        <= fv_sync_q;
      opv_prev_q       <= spi.operand_valid_in;
    end
  end

  assign spi.response_out       = response_q;
  assign spi.response_valid_out = response_valid_q;
  assign capture_enable_out     = capture_enable_q;
  assign buffer_read_address_out = address_q;
  assign x_resolution_out       = x_q;
  assign y_resolution_out       = y_q;
  assign pixel_mode_out         = mode_q;

endmodule

// File: tb/tb_camera_readout_controller.sv
// Directed bench for camera_readout_controller with a one-cycle-latency frame-buffer RAM model.
module tb_camera_readout_controller;
  localparam int unsigned WW = 32;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_valid;
  logic          cap_en;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic [9:0]    x_res, y_res;
  logic [1:0]    mode;
  logic [WW-1:0] mem [4];

  int tests = 0;
  int fails = 0;

  camera_readout_controller_if bus ();

  camera_readout_controller #(
    .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW),
    .DEFAULT_X_RESOLUTION(200), .DEFAULT_Y_RESOLUTION(200)
  ) dut (
    .clock_spi_in(clk),
    .reset_spi_n_in(rst_n),
    .spi(bus.slave),
    .frame_valid_in(frame_valid),
    .capture_enable_out(cap_en),
    .buffer_read_address_out(rd_addr),
    .buffer_read_data_in(rd_data),
    .x_resolution_out(x_res),
    .y_resolution_out(y_res),
    .pixel_mode_out(mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= (rd_addr < AW'(4)) ? mem[rd_addr[1:0]] : '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op_begin(input logic [7:0] code);
    bus.op_code_in       = code;
    bus.operand_count_in = 32'd0;
    bus.op_code_valid_in = 1'b1;
    cyc(2);
  endtask

  task automatic op_end();
    bus.op_code_valid_in = 1'b0;
    bus.operand_valid_in = 1'b0;
    cyc(2);
  endtask

  task automatic strobe(input int cnt, input logic [7:0] data);
    bus.operand_count_in = 32'(cnt);
    bus.operand_in       = data;
    bus.operand_valid_in = 1'b1;
    cyc(1);
    bus.operand_valid_in = 1'b0;
    cyc(8);
  endtask

  task automatic check_status(input string tag, input logic [7:0] exp);
    op_begin(8'h24);
    check(tag, 32'(bus.response_out), 32'(exp));
    op_end();
  endtask

  task automatic check_remaining(input string tag, input logic [23:0] exp);
    logic [31:0] e;
    op_begin(8'h21);
    for (int i = 0; i < 4; i++) begin
      bus.operand_count_in = 32'(i);
      cyc(2);
      e = (i < 3) ? 32'(exp[23-8*i -: 8]) : 32'd0;
      check($sformatf("%s_b%0d", tag, i), 32'(bus.response_out), e);
    end
    op_end();
  endtask

  task automatic configure(input logic [9:0] x, input logic [9:0] y, input logic [1:0] m);
    op_begin(8'h23);
    strobe(0, {6'b0, x[9:8]});
    strobe(1, x[7:0]);
    strobe(2, {6'b0, y[9:8]});
    strobe(3, y[7:0]);
    strobe(4, {6'b0, m});
    op_end();
  endtask

  task automatic read_bytes(input string tag, input int n, input logic [7:0] exp [6]);
    op_begin(8'h22);
    cyc(3);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_%0d", tag, i), 32'(bus.response_out), 32'(exp[i]));
      strobe(i, 8'h00);
    end
    op_end();
  endtask

  logic [7:0] rd_exp  [6];
  logic [7:0] sat_exp [6];

  initial begin
    mem[0] = 32'hAABBCCDD;
    mem[1] = 32'h11223344;
    mem[2] = 32'h0;
    mem[3] = 32'h0;
    rd_exp  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    sat_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00};
    rst_n = 1'b0;
    frame_valid = 1'b0;
    bus.op_code_in = 8'h00;
    bus.op_code_valid_in = 1'b0;
    bus.operand_in = 8'h00;
    bus.operand_valid_in = 1'b0;
    bus.operand_count_in = 32'd0;
    cyc(3);
    check("rst_cap_en", 32'(cap_en), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_resp", 32'(bus.response_out), 32'd0);
    check("rst_resp_valid", 32'(bus.response_valid_out), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    check("rst_x", 32'(x_res), 32'd200);
    check("rst_y", 32'(y_res), 32'd200);
    check("rst_mode", 32'(mode), 32'd1);
    check_remaining("avail_rst", 24'd40000);
    check_status("status_idle", 8'h00);

    // Response valid tracks op_code_valid with one cycle of delay.
    bus.op_code_in = 8'h24;
    bus.op_code_valid_in = 1'b1;
    cyc(1);
    check("resp_valid_rise", 32'(bus.response_valid_out), 32'd1);
    bus.op_code_valid_in = 1'b0;
    cyc(1);
    check("resp_valid_fall", 32'(bus.response_valid_out), 32'd0);
    bus.op_code_in = 8'h55;
    bus.op_code_valid_in = 1'b1;
    cyc(2);
    check("unknown_op_resp", 32'(bus.response_out), 32'd0);
    check("unknown_op_valid", 32'(bus.response_valid_out), 32'd1);
    op_end();

    // Arm and capture one frame.
    op_begin(8'h20);
    op_end();
    check_status("status_armed", 8'h01);
    frame_valid = 1'b1;
    cyc(2);
    check("cap_en_lat2", 32'(cap_en), 32'd0);
    cyc(1);
    check("cap_en_lat3", 32'(cap_en), 32'd1);
    check_status("status_capturing", 8'h02);
    op_begin(8'h20);
    op_end();
    check_status("capture_ignored", 8'h02);
    configure(10'd320, 10'd240, 2'd2);
    check("cfg_locked_x", 32'(x_res), 32'd200);
    check("cfg_locked_y", 32'(y_res), 32'd200);
    check("cfg_locked_mode", 32'(mode), 32'd1);
    cyc(880);
    frame_valid = 1'b0;
    cyc(2);
    check("cap_en_fall_lat2", 32'(cap_en), 32'd1);
    cyc(1);
    check("cap_en_fall_lat3", 32'(cap_en), 32'd0);
    check_status("status_done", 8'h04);

    read_bytes("read", 6, rd_exp);
    check("read_addr", 32'(rd_addr), 32'd1);
    check_remaining("avail_after_read", 24'd39994);

    // Back to IDLE and reconfigure; oversized frame clamps to buffer capacity.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    configure(10'd320, 10'd240, 2'd2);
    check("cfg_x", 32'(x_res), 32'd320);
    check("cfg_y", 32'(y_res), 32'd240);
    check("cfg_mode", 32'(mode), 32'd2);
    check_remaining("avail_clamp", 24'd65536);

    configure(10'd4, 10'd2, 2'd0);
    check_remaining("avail_small", 24'd4);
    read_bytes("sat", 6, sat_exp);
    check_remaining("avail_sat", 24'd0);
    configure(10'd3, 10'd3, 2'd0);
    check_remaining("avail_gray_odd", 24'd1);
    configure(10'd3, 10'd3, 2'd3);
    check_remaining("avail_mode3", 24'd5);

    // Reset in the middle of a capture.
    op_begin(8'h20);
    op_end();
    frame_valid = 1'b1;
    cyc(4);
    check("cap_en_before_rst", 32'(cap_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("cap_en_async_rst", 32'(cap_en), 32'd0);
    frame_valid = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check_status("status_after_rst", 8'h00);
    check("rst_x_restore", 32'(x_res), 32'd200);
    check("rst_mode_restore", 32'(mode), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
